uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx / uart_rx family and the byte arbiters
// that sit in front of the serializer.
package uart_pkg;

  localparam int BAUD_RATE = 115200;
  localparam int CLK_HZ    = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } arb_state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N_REQ, returned as one-hot grant plus index.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand_idx [N_REQ];

  // cand_idx[k] is the requester examined at scan position k (ptr+1+k mod N).
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = ((int'(ptr) + gi + 1) >= N_REQ)
                            ? PTR_W'(int'(ptr) + gi + 1 - N_REQ)
                            : PTR_W'(int'(ptr) + gi + 1);
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[cand_idx[k]]) begin
        any                 = 1'b1;
        idx                 = cand_idx[k];
        grant[cand_idx[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte streams, granting a whole
// packet at a time in round-robin order.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 i_Clk,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  input  logic [N_REQ-1:0]     i_req_last,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy
);

  localparam int PTR_W   = clog2(N_REQ);
  localparam int BURST_W = clog2(MAX_BURST + 1);
  localparam int TO_W    = clog2(IDLE_TIMEOUT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(IDLE_TIMEOUT - 1);

  arb_state_t         state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [PTR_W-1:0]   gidx_reg, gidx_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [BURST_W-1:0] burst_reg, burst_next;
  logic [TO_W-1:0]    to_reg, to_next;
  logic [7:0]         data_reg, data_next;
  logic               last_reg, last_next;

  logic [N_REQ-1:0]   pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [N_REQ-1:0]   ready_mask;
  logic               handshake;
  logic [7:0]         req_bytes [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = i_req_data[8*gi +: 8];
    end
  endgenerate

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign ready_mask = (state_reg == ST_ACCEPT) ? (grant_reg & i_req_valid) : '0;
  assign handshake  = |ready_mask;

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      ptr_reg   <= PTR_W'(N_REQ - 1);
      burst_reg <= '0;
      to_reg    <= '0;
      data_reg  <= 8'h00;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      ptr_reg   <= ptr_next;
      burst_reg <= burst_next;
      to_reg    <= to_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    ptr_next   = ptr_reg;
    burst_next = burst_reg;
    to_next    = to_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next = pick_grant;
          gidx_next  = pick_idx;
          burst_next = '0;
          to_next    = '0;
          state_next = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (handshake) begin
          data_next  = req_bytes[gidx_reg];
          last_next  = i_req_last[gidx_reg];
          if (burst_reg != BURST_MAX) burst_next = burst_reg + 1'b1;
          state_next = ST_START;
        end else if (to_reg == TO_LAST) begin
          grant_next = '0;
          ptr_next   = gidx_reg;
          state_next = ST_IDLE;
        end else begin
          to_next = to_reg + 1'b1;
        end
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        // One release covers both the last flag and the burst cap together.
        if (i_tx_done) begin
          if (last_reg || (burst_reg == BURST_MAX)) begin
            grant_next = '0;
            ptr_next   = gidx_reg;
            state_next = ST_IDLE;
          end else begin
            to_next    = '0;
            state_next = ST_ACCEPT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_req_ready = ready_mask;
  assign o_grant     = grant_reg;
  assign o_tx_start  = (state_reg == ST_START);
  assign o_tx_data   = data_reg;
  assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-source queues, a 10-cycle uart_tx
// done model and a negedge monitor logging every serializer start.
`define CHECK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_uart_tx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } item_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           start;
  logic [7:0]     txd;
  logic           done;
  logic           busy;
  logic           model_done = 1'b0;
  logic           spur_done  = 1'b0;

  assign done = model_done | spur_done;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(4), .IDLE_TIMEOUT(16)) dut (
    .i_Clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .o_tx_start  (start),
    .o_tx_data   (txd),
    .i_tx_done   (done),
    .o_busy      (busy)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  item_t        srcq [N][$];
  logic [N-1:0] hs_pend = '0;
  logic [7:0]   log_data[$];
  int           log_owner[$];
  logic [N-1:0] grant_seq[$];
  int           done_q[$];
  int           rel_q[$];
  int           cyc = 0;
  int           last_hs_cyc = -10;
  int           err_lat = 0, err_start = 0, err_hold = 0, n_starts = 0;
  logic         prev_start = 1'b0;
  logic         in_flight = 1'b0;
  logic [7:0]   hold_data = 8'h00;
  logic [N-1:0] prev_grant = '0;
  int           dcnt = 0;

  int         exp2_own [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp2_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h15};
  int         exp3_own [7] = '{2, 2, 2, 2, 1, 2, 2};
  logic [7:0] exp3_dat [7] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'hB1, 8'h24, 8'h25};

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Monitor: negedge, when everything driven at posedge+3 has settled.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      in_flight  = 1'b0;
      prev_start = 1'b0;
      hs_pend    = '0;
      prev_grant = '0;
    end else begin
      if (start) begin
        n_starts++;
        if (prev_start) err_start++;
        if (last_hs_cyc != cyc - 1) err_lat++;
        log_data.push_back(txd);
        log_owner.push_back(onehot_idx(grant));
        hold_data = txd;
        in_flight = 1'b1;
      end else if (in_flight) begin
        if (txd !== hold_data) err_hold++;
        if (done) begin
          in_flight = 1'b0;
          done_q.push_back(cyc);
        end
      end
      prev_start = start;
      hs_pend = req_ready & req_valid;
      if (|hs_pend) last_hs_cyc = cyc;
      if (grant !== prev_grant) begin
        if (grant != '0) grant_seq.push_back(grant);
        else rel_q.push_back(cyc);
        prev_grant = grant;
      end
    end
  end

  // Byte sources: pop on the handshake just taken, present the queue head.
  initial begin
    item_t it;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < N; k++) begin
        if (hs_pend[k] && srcq[k].size() > 0) it = srcq[k].pop_front();
        if (srcq[k].size() > 0) begin
          it = srcq[k][0];
          req_valid[k]       = 1'b1;
          req_data[8*k +: 8] = it.data;
          req_last[k]        = it.last;
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
        end
      end
    end
  end

  // uart_tx stand-in: done pulse 10 cycles after the start cycle.
  initial forever begin
    @(posedge clk);
    #3;
    model_done = 1'b0;
    if (reset) begin
      dcnt = 0;
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) model_done = 1'b1;
      end
      if (start) dcnt = 10;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    item_t it;
    it.data = d;
    it.last = l;
    srcq[k].push_back(it);
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) srcq[k].delete();
    log_data.delete();
    log_owner.delete();
    grant_seq.delete();
    done_q.delete();
    rel_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    step(2);
    reset = 1'b0;
  endtask

  // mode 0: n starts seen; 1: and the last byte done; 2: and arbiter idle.
  task automatic wait_log(input int nlog, input int mode, input int limit, input string tag);
    int c;
    c = 0;
    while (c < limit &&
           !(log_data.size() >= nlog &&
             (mode == 0 || !in_flight) && (mode < 2 || !busy))) begin
      step(1);
      c++;
    end
    `CHECK(tag, (c < limit), 1'b1)
  endtask

  initial begin
    int c;
    reset = 1'b1;
    step(3);
    `CHECK("rst_ready", req_ready, 4'b0000)
    `CHECK("rst_grant", grant, 4'b0000)
    `CHECK("rst_start", start, 1'b0)
    `CHECK("rst_busy", busy, 1'b0)
    `CHECK("rst_txdata", txd, 8'h00)
    reset = 1'b0;
    step(1);

    // Single two-byte packet from requester 0.
    push(0, 8'hA5, 1'b0);
    push(0, 8'h3C, 1'b1);
    wait_log(2, 2, 400, "t1_wait");
    `CHECK("t1_data0", log_data[0], 8'hA5)
    `CHECK("t1_data1", log_data[1], 8'h3C)
    `CHECK("t1_own0", log_owner[0], 0)
    `CHECK("t1_own1", log_owner[1], 0)
    `CHECK("t1_gseq_n", grant_seq.size(), 1)
    `CHECK("t1_gseq0", grant_seq[0], 4'b0001)
    `CHECK("t1_grant_end", grant, 4'b0000)

    // Round robin over four single-byte packets.
    do_reset();
    push(0, 8'h11, 1'b1);
    push(0, 8'h15, 1'b1);
    push(1, 8'h22, 1'b1);
    push(2, 8'h33, 1'b1);
    push(3, 8'h44, 1'b1);
    wait_log(5, 2, 800, "t2_wait");
    `CHECK("t2_count", log_data.size(), 5)
    for (int i = 0; i < 5; i++) begin
      `CHECK($sformatf("t2_own%0d", i), log_owner[i], exp2_own[i])
      `CHECK($sformatf("t2_dat%0d", i), log_data[i], exp2_dat[i])
    end
    `CHECK("t2_gseq_n", grant_seq.size(), 5)

    // Burst cap of 4 with requester 1 waiting.
    do_reset();
    for (int i = 0; i < 6; i++) push(2, 8'(8'h20 + i), 1'b0);
    c = 0;
    while (grant !== 4'b0100 && c < 50) begin
      step(1);
      c++;
    end
    `CHECK("t3_first_grant", grant, 4'b0100)
    push(1, 8'hB1, 1'b1);
    wait_log(7, 2, 1500, "t3_wait");
    `CHECK("t3_count", log_data.size(), 7)
    for (int i = 0; i < 7; i++) begin
      `CHECK($sformatf("t3_own%0d", i), log_owner[i], exp3_own[i])
      `CHECK($sformatf("t3_dat%0d", i), log_data[i], exp3_dat[i])
    end
    `CHECK("t3_gseq_n", grant_seq.size(), 3)

    // Idle timeout with a spurious done while in ACCEPT.
    do_reset();
    push(1, 8'h5A, 1'b0);
    push(2, 8'h6B, 1'b1);
    wait_log(1, 1, 300, "t4_done");
    step(3);
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    step(2);
    `CHECK("t4_spur_grant", grant, 4'b0010)
    `CHECK("t4_spur_busy", busy, 1'b1)
    `CHECK("t4_spur_nostart", log_data.size(), 1)
    wait_log(2, 2, 300, "t4_wait");
    `CHECK("t4_release_delay", rel_q[0] - done_q[0], 17)
    `CHECK("t4_own0", log_owner[0], 1)
    `CHECK("t4_dat0", log_data[0], 8'h5A)
    `CHECK("t4_own1", log_owner[1], 2)
    `CHECK("t4_dat1", log_data[1], 8'h6B)

    // Reset while requester 3's byte is in flight.
    do_reset();
    push(3, 8'h77, 1'b1);
    wait_log(1, 0, 100, "t5_start");
    step(3);
    `CHECK("t5_pre_grant", grant, 4'b1000)
    `CHECK("t5_pre_data", txd, 8'h77)
    reset = 1'b1;
    #1;
    `CHECK("t5_rst_ready", req_ready, 4'b0000)
    `CHECK("t5_rst_grant", grant, 4'b0000)
    `CHECK("t5_rst_start", start, 1'b0)
    `CHECK("t5_rst_busy", busy, 1'b0)
    `CHECK("t5_rst_txdata", txd, 8'h00)
    clear_all();
    step(2);
    push(0, 8'h81, 1'b1);
    push(3, 8'h83, 1'b1);
    reset = 1'b0;
    wait_log(2, 2, 400, "t5_wait");
    `CHECK("t5_own0", log_owner[0], 0)
    `CHECK("t5_dat0", log_data[0], 8'h81)
    `CHECK("t5_own1", log_owner[1], 3)
    `CHECK("t5_dat1", log_data[1], 8'h83)

    // Handshake-to-start latency, start width and data hold over the whole run.
    `CHECK("start_latency_errs", err_lat, 0)
    `CHECK("start_width_errs", err_start, 0)
    `CHECK("data_hold_errs", err_hold, 0)
    `CHECK("total_starts", n_starts, 19)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
